// File: rtl/serial_digit_rx_if.sv
// Link pins of the digit serial receiver plus its parallel result; the transmitter
// side (or bench) uses master, the receiver uses slave.
interface serial_digit_rx_if #(
    parameter int WIDTH = 32
);
    logic             sclk;
    logic             data_enable;
    logic             sdi;
    logic             dclk;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             frame_err;
    logic             busy;

    modport master (
        output sclk, data_enable, sdi, dclk,
        input  data_out, data_valid, frame_err, busy
    );

    modport slave (
        input  sclk, data_enable, sdi, dclk,
        output data_out, data_valid, frame_err, busy
    );
endinterface

// File: rtl/serial_digit_rx.sv
// Purpose: deserialise the sclk/data_enable/sdi/dclk digit link into a parallel word.
// Latency: result pulse a few clk after the completing pin edge (synchroniser depth + edge detect + output register).
// Backpressure: none, the link cannot be stalled; RX_DIGIT_CHECK_EN rejects words containing non-BCD nibbles.
module serial_digit_rx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter bit SAMPLE_RISE = 1'b1
) (
    input logic              clk,
    input logic              rst,
    serial_digit_rx_if.slave link
);
    localparam int CNT_W    = $clog2(WIDTH) + 1;
    localparam int SET_W    = $clog2(SYNC_STAGES + 1) + 1;
    localparam int PIN_SCLK = 0;
    localparam int PIN_DE   = 1;
    localparam int PIN_SDI  = 2;
    localparam int PIN_DCLK = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_END
    } state_t;

    logic [3:0]                   pins;
    logic [SYNC_STAGES-1:0][3:0]  sync_q, sync_d;
    logic [3:0]                   synced;
    logic [2:0]                   prev_q, prev_d;
    logic [SET_W-1:0]             settle_q, settle_d;
    logic                         settled;
    logic                         armed_q, armed_d;

    logic                         sclk_rise, sclk_fall, sclk_edge;
    logic                         de_rise, de_fall, dclk_rise, sdi_s;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]             shift_q, shift_d;
    logic [WIDTH-1:0]             data_out_q, data_out_d;
    logic                         data_valid_q, data_valid_d;
    logic                         frame_err_q, frame_err_d;
    logic                         complete, digit_bad;

`ifdef RX_DIGIT_CHECK_EN
    function automatic logic has_bad_nibble(input logic [WIDTH-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int n = 0; n < WIDTH / 4; n++) begin
            if (w[4*n +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction
`endif

    assign pins = {link.dclk, link.sdi, link.data_enable, link.sclk};

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = pins;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign prev_d = {synced[PIN_DCLK], synced[PIN_DE], synced[PIN_SCLK]};

    assign sclk_rise = synced[PIN_SCLK] & ~prev_q[0];
    assign sclk_fall = ~synced[PIN_SCLK] & prev_q[0];
    assign sclk_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign de_rise   = synced[PIN_DE] & ~prev_q[1];
    assign de_fall   = ~synced[PIN_DE] & prev_q[1];
    assign dclk_rise = synced[PIN_DCLK] & ~prev_q[2];
    assign sdi_s     = synced[PIN_SDI];

    // The synchroniser holds zeros for SYNC_STAGES cycles after reset, so an enable
    // already high would look like a rise; only arm once a genuine low has been seen.
    assign settled  = (settle_q == SET_W'(SYNC_STAGES));
    assign settle_d = settled ? settle_q : settle_q + SET_W'(1);
    assign armed_d  = armed_q | (settled & ~synced[PIN_DE]);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        complete     = 1'b0;
        digit_bad    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (armed_q && de_rise) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            SHIFT: begin
                if (sclk_edge) begin
                    shift_d   = {shift_q[WIDTH-2:0], sdi_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
                // The bit arriving with the enable fall counts before the fall is judged.
                if (bit_cnt_d == CNT_W'(WIDTH)) begin
                    if (de_fall || dclk_rise) begin
                        complete = 1'b1;
                    end else begin
                        state_d = WAIT_END;
                    end
                end else if (de_fall) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WAIT_END: begin
                if (de_fall || dclk_rise) begin
                    complete = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (complete) begin
`ifdef RX_DIGIT_CHECK_EN
            digit_bad = has_bad_nibble(shift_d);
`endif
            state_d = IDLE;
            if (digit_bad) begin
                frame_err_d = 1'b1;
            end else begin
                data_out_d   = shift_d;
                data_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            prev_q       <= '0;
            settle_q     <= '0;
            armed_q      <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            settle_q     <= settle_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign link.data_out   = data_out_q;
    assign link.data_valid = data_valid_q;
    assign link.frame_err  = frame_err_q;
    assign link.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_digit_rx.sv
// Bench for serial_digit_rx: table of whole frames plus reset corner sequences,
// with a scoreboard of expected data_valid / frame_err pulses.
module tb_serial_digit_rx;
    localparam int W    = 32;
    localparam int HALF = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serial_digit_rx_if #(.WIDTH(W)) link_if ();

    serial_digit_rx #(
        .WIDTH      (W),
        .SYNC_STAGES(2),
        .SAMPLE_RISE(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .link(link_if)
    );

    typedef struct {
        logic         is_err;
        logic [W-1:0] dat;
    } exp_t;

    typedef enum {END_DCLK, END_DE} end_t;

    typedef struct {
        logic [W-1:0] word;
        int           nbits;
        int           extra;
        end_t         ending;
        logic         exp_err;
        logic [W-1:0] exp_out;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   errors = 0;
    int   checks = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_pulse(input logic is_err, input logic [W-1:0] dat);
        exp_t e;
        e.is_err = is_err;
        e.dat    = dat;
        sb_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        link_if.sdi  = b;
        link_if.sclk = 1'b0;
        tick(HALF);
        link_if.sclk = 1'b1;
        tick(HALF);
    endtask

    task automatic run_frame(input vec_t v);
        link_if.data_enable = 1'b1;
        tick(HALF);
        for (int i = 0; i < v.nbits; i++) send_bit(v.word[W-1-i]);
        for (int i = 0; i < v.extra; i++) send_bit(1'b1);
        link_if.sclk = 1'b0;
        tick(HALF);
        if (v.ending == END_DCLK) begin
            link_if.dclk = 1'b1;
            tick(HALF);
            link_if.dclk = 1'b0;
            tick(HALF);
        end
        link_if.data_enable = 1'b0;
        link_if.sdi         = 1'b0;
        tick(4 * HALF);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulses outstanding after %0d cycles, required 0", name, sb_q.size(), n);
            sb_q.delete();
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (link_if.data_valid || link_if.frame_err)) begin
                if (link_if.data_valid && link_if.frame_err) begin
                    check("valid_and_err", W'(1), W'(0));
                end else if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got valid=%0b err=%0b data_out=%h, required no pulse",
                             link_if.data_valid, link_if.frame_err, link_if.data_out);
                end else begin
                    e = sb_q.pop_front();
                    check("pulse_is_err", W'(link_if.frame_err), W'(e.is_err));
                    if (!e.is_err) check("pulse_data_out", link_if.data_out, e.dat);
                end
            end
        end
    endtask

    initial begin
        vec_t v;
        link_if.sclk        = 1'b0;
        link_if.data_enable = 1'b0;
        link_if.sdi         = 1'b0;
        link_if.dclk        = 1'b0;

        vecs[0] = '{32'h00006942, 32, 0, END_DCLK, 1'b0, 32'h00006942};
        vecs[1] = '{32'h12345678, 32, 0, END_DCLK, 1'b0, 32'h12345678};
        vecs[2] = '{32'h00000009, 32, 0, END_DE,   1'b0, 32'h00000009};
        vecs[3] = '{32'h5A5A5A5A, 17, 0, END_DE,   1'b1, 32'h00000009};
        vecs[4] = '{32'h00006942, 32, 3, END_DE,   1'b0, 32'h00006942};
`ifdef RX_DIGIT_CHECK_EN
        vecs[5] = '{32'h0000A942, 32, 0, END_DCLK, 1'b1, 32'h00006942};
`else
        vecs[5] = '{32'h0000A942, 32, 0, END_DCLK, 1'b0, 32'h0000A942};
`endif

        fork
            monitor();
            begin
                repeat (50000) @(posedge clk);
                $display("FAIL watchdog: got no end of test after 50000 cycles, required finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        rst = 1'b1;
        tick(4);
        check("rst_data_out",   link_if.data_out,        '0);
        check("rst_data_valid", W'(link_if.data_valid), '0);
        check("rst_frame_err",  W'(link_if.frame_err),  '0);
        check("rst_busy",       W'(link_if.busy),       '0);
        rst = 1'b0;
        tick(4);

        for (int i = 0; i < 6; i++) begin
            expect_pulse(vecs[i].exp_err, vecs[i].exp_out);
            run_frame(vecs[i]);
            drain($sformatf("vec%0d_drain", i));
            check($sformatf("vec%0d_data_out", i), link_if.data_out, vecs[i].exp_out);
            check($sformatf("vec%0d_busy", i), W'(link_if.busy), '0);
        end

        // Reset while bit 20 is on the wire: partial frame vanishes silently.
        link_if.data_enable = 1'b1;
        tick(HALF);
        for (int i = 0; i < 19; i++) send_bit(1'b1);
        link_if.sdi  = 1'b1;
        link_if.sclk = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        link_if.data_enable = 1'b0;
        link_if.sclk        = 1'b0;
        tick(3);
        check("midrst_data_out", link_if.data_out,  '0);
        check("midrst_busy",     W'(link_if.busy), '0);
        rst = 1'b0;
        tick(20);
        check("midrst_busy_after", W'(link_if.busy), '0);
        check("midrst_data_after", link_if.data_out,  '0);
        v = '{32'h00001234, 32, 0, END_DCLK, 1'b0, 32'h00001234};
        expect_pulse(1'b0, v.exp_out);
        run_frame(v);
        drain("after_midrst_drain");
        check("after_midrst_data_out", link_if.data_out, 32'h00001234);

        // Enable held high across reset release must not start a frame.
        link_if.data_enable = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(10);
        for (int i = 0; i < W; i++) send_bit(1'b0);
        link_if.sclk = 1'b0;
        tick(HALF);
        check("dehigh_busy", W'(link_if.busy), '0);
        link_if.dclk = 1'b1;
        tick(HALF);
        link_if.dclk = 1'b0;
        tick(10);
        check("dehigh_data_out", link_if.data_out, '0);
        link_if.data_enable = 1'b0;
        tick(4 * HALF);
        v = '{32'h00000015, 32, 0, END_DE, 1'b0, 32'h00000015};
        expect_pulse(1'b0, v.exp_out);
        run_frame(v);
        drain("after_dehigh_drain");
        check("after_dehigh_data_out", link_if.data_out, 32'h00000015);
        check("final_busy", W'(link_if.busy), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
